// File: rtl/fmtparams_q.sv
// Floating-point format parameter lookup (bias, fraction bits, exponent width)
// feeding a small tagged FIFO, with a saturating count of illegal requests.
module fmtparams_q #(
  parameter int          NE      = 15,
  parameter int          LOGFLEN = 7,
  parameter logic [3:0]  FMTEN   = 4'b1111,
  parameter int          DEPTH   = 2,
  parameter int          TAGW    = 5,
  parameter int          CNTW    = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [1:0]                Fmt,
  input  logic [TAGW-1:0]           InTag,
  input  logic [3:0]                FmtEnDyn,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [NE-2:0]             Bias,
  output logic [LOGFLEN-1:0]        Nf,
  output logic [$clog2(NE+1)-1:0]   Ne,
  output logic                      Illegal,
  output logic [TAGW-1:0]           OutTag,
  input  logic                      ClrCnt,
  output logic [CNTW-1:0]           IllegalCnt
);

  localparam int BW  = NE - 1;
  localparam int NEW = $clog2(NE + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  function automatic int fmtNe(input logic [1:0] f);
    case (f)
      2'd0:    return 8;
      2'd1:    return 11;
      2'd2:    return 5;
      default: return 15;
    endcase
  endfunction

  function automatic int fmtNf(input logic [1:0] f);
    case (f)
      2'd0:    return 23;
      2'd1:    return 52;
      2'd2:    return 10;
      default: return 112;
    endcase
  endfunction

  function automatic int fmtBias(input logic [1:0] f);
    return (1 << (fmtNe(f) - 1)) - 1;
  endfunction

  // Any enabled format must fit the configured output widths.
  for (genvar i = 0; i < 4; i++) begin : g_fmtChk
    if (FMTEN[i] && ((fmtNe(2'(i)) > NE) || (fmtNf(2'(i)) >= (1 << LOGFLEN)))) begin : g_bad
      $error("fmtparams_q: enabled format %0d does not fit NE/LOGFLEN", i);
    end
  end

  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_depthChk
    $error("fmtparams_q: DEPTH %0d outside 1..8", DEPTH);
  end

  typedef struct packed {
    logic               ill;
    logic [BW-1:0]      bias;
    logic [LOGFLEN-1:0] nf;
    logic [NEW-1:0]     ne;
    logic [TAGW-1:0]    tag;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          lk;
  entry_t          head;
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CW-1:0]   count;
  logic            rstSync;
  logic            legal;
  logic            push;
  logic            pop;
  logic [CNTW-1:0] illegalCnt;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Disabled formats still enqueue, carrying only the tag and the flag.
  always_comb begin
    lk     = '0;
    legal  = FMTEN[Fmt] & FmtEnDyn[Fmt];
    lk.tag = InTag;
    if (!legal) begin
      lk.ill = 1'b1;
    end else begin
      lk.bias = BW'(fmtBias(Fmt));
      lk.nf   = LOGFLEN'(fmtNf(Fmt));
      lk.ne   = NEW'(fmtNe(Fmt));
    end
  end

  // Reset release is retimed through one flop so InReady rises cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rstSync <= 1'b0;
    else          rstSync <= 1'b1;
  end

  assign InReady  = rstSync && (count < CW'(DEPTH));
  assign OutValid = (count != '0);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= lk;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A clear that coincides with an illegal acceptance counts that request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegalCnt <= '0;
    end else if (push && lk.ill) begin
      if (ClrCnt)                 illegalCnt <= CNTW'(1);
      else if (illegalCnt != '1)  illegalCnt <= illegalCnt + CNTW'(1);
    end else if (ClrCnt) begin
      illegalCnt <= '0;
    end
  end

  always_comb begin
    head = OutValid ? mem[rdPtr] : '0;
  end

  assign Bias       = head.bias;
  assign Nf         = head.nf;
  assign Ne         = head.ne;
  assign Illegal    = head.ill;
  assign OutTag     = head.tag;
  assign IllegalCnt = illegalCnt;

endmodule

// File: tb/tb_fmtparams_q.sv
// Bench for fmtparams_q: a default instance driven from a vector table and
// a DEPTH=3/CNTW=2 instance driven randomly against a queue-based model.
module tb_fmtparams_q;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance (A)
  logic        inValidA = 0, outReadyA = 0, clrCntA = 0;
  logic [1:0]  fmtA = 0;
  logic [4:0]  inTagA = 0;
  logic [3:0]  fmtEnDynA = 4'hF;
  logic        inReadyA, outValidA, illegalA;
  logic [13:0] biasA;
  logic [6:0]  nfA;
  logic [3:0]  neA;
  logic [4:0]  outTagA;
  logic [7:0]  illegalCntA;

  // DEPTH=3, CNTW=2 instance (B)
  logic        inValidB = 0, outReadyB = 0, clrCntB = 0;
  logic [1:0]  fmtB = 0;
  logic [4:0]  inTagB = 0;
  logic [3:0]  fmtEnDynB = 4'hF;
  logic        inReadyB, outValidB, illegalB;
  logic [13:0] biasB;
  logic [6:0]  nfB;
  logic [3:0]  neB;
  logic [4:0]  outTagB;
  logic [1:0]  illegalCntB;

  fmtparams_q uA (
    .clk(clk), .reset_n(reset_n),
    .InValid(inValidA), .InReady(inReadyA), .Fmt(fmtA), .InTag(inTagA),
    .FmtEnDyn(fmtEnDynA), .OutValid(outValidA), .OutReady(outReadyA),
    .Bias(biasA), .Nf(nfA), .Ne(neA), .Illegal(illegalA), .OutTag(outTagA),
    .ClrCnt(clrCntA), .IllegalCnt(illegalCntA)
  );

  fmtparams_q #(.DEPTH(3), .CNTW(2)) uB (
    .clk(clk), .reset_n(reset_n),
    .InValid(inValidB), .InReady(inReadyB), .Fmt(fmtB), .InTag(inTagB),
    .FmtEnDyn(fmtEnDynB), .OutValid(outValidB), .OutReady(outReadyB),
    .Bias(biasB), .Nf(nfB), .Ne(neB), .Illegal(illegalB), .OutTag(outTagB),
    .ClrCnt(clrCntB), .IllegalCnt(illegalCntB)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       iv;
    logic [1:0] fmt;
    int         tag;
    logic [3:0] dyn;
    logic       ordy;
    logic       clr;
    logic       ov;
    logic       ir;
    logic       ill;
    int         bias;
    int         nf;
    int         ne;
    int         etag;
    int         cnt;
  } vec_t;

  typedef struct {
    logic ill;
    int   bias;
    int   nf;
    int   ne;
    int   tag;
  } ref_t;

  function automatic logic [63:0] pk(logic ov, logic ir, logic ill, int bias,
                                     int nf, int ne, int tag, int cnt);
    return {23'd0, ov, ir, ill, 14'(bias), 7'(nf), 4'(ne), 5'(tag), 8'(cnt)};
  endfunction

  // Reference: exponent/fraction widths per IEEE format, bias = 2^(ne-1)-1.
  function automatic ref_t refEntry(logic [1:0] fmt, logic [3:0] dyn, int tag);
    ref_t r;
    int widths [4][2] = '{'{8, 23}, '{11, 52}, '{5, 10}, '{15, 112}};
    logic [3:0] staticEn = 4'b1111;
    r.tag = tag;
    if (staticEn[fmt] && dyn[fmt]) begin
      r.ill  = 1'b0;
      r.ne   = widths[fmt][0];
      r.nf   = widths[fmt][1];
      r.bias = (2 ** (r.ne - 1)) - 1;
    end else begin
      r.ill = 1'b1; r.ne = 0; r.nf = 0; r.bias = 0;
    end
    return r;
  endfunction

  function automatic logic [63:0] actualA();
    return pk(outValidA, inReadyA, illegalA, int'(biasA), int'(nfA), int'(neA),
              int'(outTagA), int'(illegalCntA));
  endfunction

  function automatic logic [63:0] actualB();
    return pk(outValidB, inReadyB, illegalB, int'(biasB), int'(nfB), int'(neB),
              int'(outTagB), int'(illegalCntB));
  endfunction

  function automatic vec_t mk(logic iv, logic [1:0] fmt, int tag, logic [3:0] dyn,
                              logic ordy, logic clr, logic ov, logic ir, logic ill,
                              int bias, int nf, int ne, int etag, int cnt);
    vec_t v;
    v.iv = iv; v.fmt = fmt; v.tag = tag; v.dyn = dyn; v.ordy = ordy; v.clr = clr;
    v.ov = ov; v.ir = ir; v.ill = ill; v.bias = bias; v.nf = nf; v.ne = ne;
    v.etag = etag; v.cnt = cnt;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    inValidA  = v.iv;
    fmtA      = v.fmt;
    inTagA    = 5'(v.tag);
    fmtEnDynA = v.dyn;
    outReadyA = v.ordy;
    clrCntA   = v.clr;
  endtask

  vec_t tbl[$];
  ref_t rq[$];
  int   modelCnt;
  ref_t e;
  ref_t hd;
  logic [63:0] expB;
  logic pushM, popM;

  initial begin
    // S=0 D=1 H=2 Q=3
    tbl.push_back(mk(0, 0, 0, 4'hF, 1, 0,  0, 1, 0,     0,   0,  0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4'hF, 1, 0,  1, 1, 0,  1023,  52, 11, 1, 0));
    tbl.push_back(mk(1, 3, 2, 4'hF, 1, 0,  1, 1, 0, 16383, 112, 15, 2, 0));
    tbl.push_back(mk(1, 2, 3, 4'hF, 1, 0,  1, 1, 0,    15,  10,  5, 3, 0));
    tbl.push_back(mk(0, 0, 0, 4'hF, 1, 0,  0, 1, 0,     0,   0,  0, 0, 0));
    tbl.push_back(mk(1, 0, 7, 4'hE, 1, 0,  1, 1, 1,     0,   0,  0, 7, 1));
    tbl.push_back(mk(0, 0, 0, 4'hF, 1, 0,  0, 1, 0,     0,   0,  0, 0, 1));
    tbl.push_back(mk(1, 0, 4, 4'hF, 0, 0,  1, 1, 0,   127,  23,  8, 4, 1));
    tbl.push_back(mk(1, 1, 5, 4'hF, 0, 0,  1, 0, 0,   127,  23,  8, 4, 1));
    tbl.push_back(mk(1, 2, 6, 4'hF, 0, 0,  1, 0, 0,   127,  23,  8, 4, 1));
    tbl.push_back(mk(1, 2, 6, 4'hF, 1, 0,  1, 1, 0,  1023,  52, 11, 5, 1));
    tbl.push_back(mk(1, 2, 6, 4'hF, 1, 0,  1, 1, 0,    15,  10,  5, 6, 1));
    tbl.push_back(mk(0, 0, 0, 4'hF, 1, 0,  0, 1, 0,     0,   0,  0, 0, 1));
    tbl.push_back(mk(1, 3, 9, 4'hF, 0, 0,  1, 1, 0, 16383, 112, 15, 9, 1));
    tbl.push_back(mk(0, 0, 0, 4'h0, 0, 0,  1, 1, 0, 16383, 112, 15, 9, 1));
    tbl.push_back(mk(0, 0, 0, 4'h0, 1, 0,  0, 1, 0,     0,   0,  0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'hF, 1, 1,  0, 1, 0,     0,   0,  0, 0, 0));

    #2;
    checkOutput("in_reset_A", actualA(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("in_reset_B", actualB(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), actualA(),
                  pk(tbl[i].ov, tbl[i].ir, tbl[i].ill, tbl[i].bias, tbl[i].nf,
                     tbl[i].ne, tbl[i].etag, tbl[i].cnt));
    end

    // Reset with two entries in flight
    applyStimulus(mk(1, 0, 1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    applyStimulus(mk(1, 2, 2, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    inValidA = 1'b0;
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_async", actualA(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("reset_held", actualA(), pk(0, 0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b1;
    applyStimulus(mk(1, 1, 11, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("post_reset_ready", actualA(), pk(0, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput("post_reset_first", actualA(), pk(1, 1, 0, 1023, 52, 11, 11, 0));
    inValidA = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_drain", actualA(), pk(0, 1, 0, 0, 0, 0, 0, 0));

    // Saturating 2-bit counter, then clear coinciding with an illegal push
    fmtEnDynB = 4'h0;
    outReadyB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inValidB = 1'b1;
      fmtB     = 2'($urandom_range(0, 3));
      inTagB   = 5'(i);
      @(negedge clk);
      checkOutput($sformatf("sat%0d", i), actualB(),
                  pk(1, 1, 1, 0, 0, 0, i, (i + 1 > 3) ? 3 : i + 1));
    end
    clrCntB = 1'b1;
    inTagB  = 5'd5;
    @(negedge clk);
    checkOutput("clr_with_push", actualB(), pk(1, 1, 1, 0, 0, 0, 5, 1));
    inValidB = 1'b0;
    @(negedge clk);
    checkOutput("clr_alone", actualB(), pk(0, 1, 0, 0, 0, 0, 0, 0));
    clrCntB = 1'b0;

    // Random traffic on the DEPTH=3 instance against a queue model
    modelCnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (rq.size() == 0) begin
        expB = pk(0, 1, 0, 0, 0, 0, 0, modelCnt);
      end else begin
        hd = rq[0];
        expB = pk(1, rq.size() < 3, hd.ill, hd.bias, hd.nf, hd.ne, hd.tag, modelCnt);
      end
      checkOutput($sformatf("rand%0d", c), actualB(), expB);

      inValidB  = 1'($urandom_range(0, 1));
      fmtB      = 2'($urandom_range(0, 3));
      inTagB    = 5'($urandom_range(0, 31));
      fmtEnDynB = 4'($urandom_range(0, 15));
      outReadyB = ($urandom_range(0, 2) != 0);
      clrCntB   = ($urandom_range(0, 7) == 0);

      pushM = inValidB && (rq.size() < 3);
      popM  = (rq.size() > 0) && outReadyB;
      if (popM) void'(rq.pop_front());
      if (pushM) begin
        e = refEntry(fmtB, fmtEnDynB, int'(inTagB));
        rq.push_back(e);
        if (e.ill) modelCnt = clrCntB ? 1 : ((modelCnt < 3) ? modelCnt + 1 : 3);
        else if (clrCntB) modelCnt = 0;
      end else if (clrCntB) begin
        modelCnt = 0;
      end
      @(negedge clk);
    end
    if (rq.size() == 0) begin
      expB = pk(0, 1, 0, 0, 0, 0, 0, modelCnt);
    end else begin
      hd = rq[0];
      expB = pk(1, rq.size() < 3, hd.ill, hd.bias, hd.nf, hd.ne, hd.tag, modelCnt);
    end
    checkOutput("rand_final", actualB(), expB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
